branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor for the 5-stage 16-bit pipeline: a direct-mapped branch target buffer with 2-bit saturating counters. It is looked up combinationally by the fetch stage on the current PC and updated on the clock edge when the decode stage resolves a B/BR. It also produces the misprediction flag that drives the IF flush and the branch-hazard path of the hazard unit.

## Interface
- INDEX_W, 4, log2 of entry count (16 entries); index = PC[INDEX_W:1], tag = PC[15:INDEX_W+1]
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- PC_curr  input  16  fetch-stage PC, lookup address
- predicted_taken  output  1  lookup prediction for PC_curr
- predicted_target  output  16  next-fetch address for PC_curr
- ID_stall  input  1  IF_ID stalled this cycle; suppresses update and mispredict
- update_en  input  1  decode stage holds a resolved B or BR
- update_PC  input  16  PC of the resolved branch
- actual_taken  input  1  resolved direction
- actual_target  input  16  resolved target (valid when actual_taken)
- IF_ID_predicted_taken  input  1  prediction carried with the branch into ID
- IF_ID_predicted_target  input  16  target carried with the branch into ID
- mispredicted  output  1  flush request for IF/IF_ID
- branch_cnt  output  16  resolved-branch count (see Configuration)
- mispredict_cnt  output  16  misprediction count (see Configuration)

## Operation
- Entry = {valid, tag, ctr[1:0], target[15:0]}. ctr: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational): hit = valid & tag match. predicted_taken = hit & ctr[1]. predicted_target = predicted_taken ? target : PC_curr+2 (mod 2^16; 0xFFFE -> 0x0000).
- Effective update upd = update_en & ~ID_stall.
- On upd with hit at update_PC: ctr saturating +1 if actual_taken, -1 otherwise; target <= actual_target if actual_taken, else unchanged.
- On upd with miss: if actual_taken, allocate (overwrite any occupant): valid=1, tag, ctr=10, target=actual_target. If not taken, no write.
- mispredicted = upd & ((IF_ID_predicted_taken != actual_taken) | (actual_taken & IF_ID_predicted_target != actual_target)). Zero when ~upd.
- PC bit 0 ignored for index and tag.

## Timing
- Lookup: zero latency, same cycle as PC_curr.
- Update: written on the rising edge ending the upd cycle; visible to lookups from the next cycle.
- Same-cycle lookup and update of one entry: lookup returns pre-update state; no bypass.
- mispredicted: combinational in the upd cycle; the caller registers/flushes on the same edge.
- ID_stall held N cycles with update_en high: exactly one update, on the first unstalled cycle.
- Reset (async, any time including mid-update): all valid=0, ctr=01, target=0x0000, counters=0. Post-reset outputs: predicted_taken=0, predicted_target=PC_curr+2, mispredicted=0. A write racing reset deassertion is discarded.

## Configuration
- BP_PERF_CNT_EN defined: branch_cnt increments on every upd; mispredict_cnt increments when upd & mispredicted; both saturate at 0xFFFF, reset to 0.
- Undefined: counter registers not built; branch_cnt and mispredict_cnt tied to 0x0000. Prediction behaviour identical.

## Test plan
- Reset, PC_curr=0x0010 -> predicted_taken=0, predicted_target=0x0012; PC_curr=0xFFFE -> predicted_target=0x0000.
- Taken B at 0x0008 to 0x0040, IF_ID_predicted_taken=0 -> mispredicted=1 in update cycle; next cycle PC_curr=0x0008 -> taken, target 0x0040.
- Same branch resolved not-taken three times -> ctr 10->01->00->00; predicted_taken=0 from the first not-taken update onward; mispredicted=1 only when carried prediction was taken.
- Alias: entry at 0x0008 valid; taken branch at 0x0028 (same index) to 0x0100 -> entry replaced; 0x0008 lookup misses, 0x0028 hits with 0x0100.
- Hit predicted taken to 0x0040, actual target 0x0050 -> mispredicted=1, target updated to 0x0050.
- update_en high with ID_stall high 3 cycles then low -> mispredicted only in final cycle, one ctr step; with BP_PERF_CNT_EN, branch_cnt +1; counters at 0xFFFF hold.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Dynamic branch predictor for the 5-stage 16-bit pipeline.
//             Direct-mapped branch target buffer with 2-bit saturating
//             counters. Looked up combinationally by fetch on PC_curr and
//             updated on the clock edge when decode resolves a B/BR. Also
//             produces the misprediction flush request.
//  Ports    : clk, rst_n                  - clock, async active-low reset
//             PC_curr                     - fetch lookup address
//             predicted_taken/_target     - lookup result for PC_curr
//             ID_stall, update_en         - update qualifier / request
//             update_PC, actual_taken,
//             actual_target               - resolved branch information
//             IF_ID_predicted_taken/_target - prediction carried into ID
//             mispredicted                - flush request for IF/IF_ID
//             branch_cnt, mispredict_cnt  - performance counters
//  Options  : BP_PERF_CNT_EN - build saturating performance counters;
//             when undefined both counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_curr,
    output logic        predicted_taken,
    output logic [15:0] predicted_target,
    input  logic        ID_stall,
    input  logic        update_en,
    input  logic [15:0] update_PC,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        IF_ID_predicted_taken,
    input  logic [15:0] IF_ID_predicted_target,
    output logic        mispredicted,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispredict_cnt
);

    localparam int c_ENTRIES = 1 << INDEX_W;
    localparam int c_TAG_W   = 15 - INDEX_W;

    logic [c_ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0]   r_tag    [c_ENTRIES];
    logic [1:0]           r_ctr    [c_ENTRIES];
    logic [15:0]          r_target [c_ENTRIES];

    // Instruction PCs are halfword aligned, so bit 0 carries no information.
    logic [INDEX_W-1:0] w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic [INDEX_W-1:0] w_up_idx;
    logic [c_TAG_W-1:0] w_up_tag;
    logic               w_up_hit;
    logic               w_upd;
    logic               w_unused_pc_lsb;

    assign w_lk_idx = PC_curr[INDEX_W:1];
    assign w_lk_tag = PC_curr[15:INDEX_W+1];
    assign w_up_idx = update_PC[INDEX_W:1];
    assign w_up_tag = update_PC[15:INDEX_W+1];
    assign w_unused_pc_lsb = PC_curr[0] ^ update_PC[0];

    // ------------------------------------------------------------------
    // Lookup: reads the stored state only, so a same-cycle update to the
    // same entry is not forwarded.
    // ------------------------------------------------------------------
    assign w_lk_hit         = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign predicted_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign predicted_target = predicted_taken ? r_target[w_lk_idx] : (PC_curr + 16'd2);

    // ------------------------------------------------------------------
    // Update qualification and misprediction detection. A stalled decode
    // stage keeps presenting the same branch, so it only counts once the
    // stall drops.
    // ------------------------------------------------------------------
    assign w_upd    = update_en && !ID_stall;
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign mispredicted = w_upd &&
                          ((IF_ID_predicted_taken != actual_taken) ||
                           (actual_taken && (IF_ID_predicted_target != actual_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= 2'b01;
                r_target[i] <= 16'h0000;
            end
        end else if (w_upd) begin
            if (w_up_hit) begin
                if (actual_taken) begin
                    if (r_ctr[w_up_idx] != 2'b11) begin
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
                    end
                    r_target[w_up_idx] <= actual_target;
                end else if (r_ctr[w_up_idx] != 2'b00) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
                end
            end else if (actual_taken) begin
                // Allocate on a taken miss, evicting any aliasing occupant;
                // a new entry starts weakly taken.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_ctr[w_up_idx]    <= 2'b10;
                r_target[w_up_idx] <= actual_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (optional)
    // ------------------------------------------------------------------
`ifdef BP_PERF_CNT_EN
    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispredict_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt     <= 16'h0000;
            r_mispredict_cnt <= 16'h0000;
        end else if (w_upd) begin
            if (r_branch_cnt != 16'hFFFF) begin
                r_branch_cnt <= r_branch_cnt + 16'd1;
            end
            if (mispredicted && (r_mispredict_cnt != 16'hFFFF)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
`else
    assign branch_cnt     = 16'h0000;
    assign mispredict_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
